// File: rtl/per_out_fifo_if.sv
// Bus bundle for per_out_fifo: openMSP430 peripheral access plus the
// valid/ready output stream and the sticky done flag.
//   per_en/per_we/per_addr/per_din : CPU peripheral write/read request
//   per_dout                       : combinational read data (0 when not selected)
//   out_valid/out_data/out_ready   : FIFO head stream toward the consumer
//   done                           : a 0x0000 word has been popped
// Modport master is the CPU/consumer side, slave is the FIFO.
interface per_out_fifo_if;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        done;

  modport master (
    output per_en, per_we, per_addr, per_din, out_ready,
    input  per_dout, out_valid, out_data, done
  );

  modport slave (
    input  per_en, per_we, per_addr, per_din, out_ready,
    output per_dout, out_valid, out_data, done
  );
endinterface

// File: rtl/per_out_fifo.sv
// Program-output port: CPU word writes to DATA are queued in a FIFO and
// drained over a valid/ready stream. STATUS and CTRL allow software polling.
// Register block (word offsets from BASE_ADDR):
//   0 DATA   : write pushes, read returns head (no pop), 0 when empty
//   1 STATUS : [0] empty [1] full [2] overflow [3] done [15:8] level
//   2 CTRL   : write bit0 clears overflow/done, bit1 flushes; reads 0
//   3 reserved
// Ports:
//   mclk    : system clock
//   puc_rst : synchronous active-high reset
//   bus     : per_out_fifo_if.slave (peripheral bus + output stream + done)
module per_out_fifo #(
  parameter logic [13:0] BASE_ADDR  = 14'h0080,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic          mclk,
  input  logic          puc_rst,
  per_out_fifo_if.slave bus
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam int                LW       = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]     FULL_LVL = LW'(1) << DEPTH_LOG2;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  done_q;

  logic        sel;
  logic [1:0]  idx;
  logic        wr_any;
  logic        push_req;
  logic        ctrl_wr;
  logic        flush;
  logic        clr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        ovf_set;
  logic        done_set;
  logic [15:0] head;
  logic [15:0] push_word;
  logic [15:0] status;

  assign sel      = bus.per_en && (bus.per_addr[13:2] == BASE_ADDR[13:2]);
  assign idx      = bus.per_addr[1:0];
  assign wr_any   = |bus.per_we;
  assign push_req = sel && wr_any && (idx == 2'd0);
  assign ctrl_wr  = sel && wr_any && (idx == 2'd2);
  assign flush    = ctrl_wr && bus.per_din[1];
  assign clr      = ctrl_wr && bus.per_din[0];

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign head  = empty ? 16'h0000 : mem[rd_ptr];

  // Flush suppresses any pop in the same cycle.
  assign pop      = !empty && bus.out_ready && !flush;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign done_set = pop && (head == 16'h0000);

  assign push_word = {bus.per_we[1] ? bus.per_din[15:8] : 8'h00,
                      bus.per_we[0] ? bus.per_din[7:0]  : 8'h00};

  assign status = {8'(level), 4'b0000, done_q, overflow, full, empty};

  always_comb begin
    bus.per_dout = 16'h0000;
    if (sel && !wr_any) begin
      case (idx)
        2'd0:    bus.per_dout = head;
        2'd1:    bus.per_dout = status;
        default: bus.per_dout = 16'h0000;
      endcase
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.done      = done_q;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      end
      // Set beats clear when both land in the same cycle.
      if (ovf_set)  overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
      if (done_set) done_q <= 1'b1;
      else if (clr) done_q <= 1'b0;
    end
  end

  // Storage is not reset; contents are never visible while empty.
  always_ff @(posedge mclk) begin
    if (!puc_rst && push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_per_out_fifo.sv
module tb_per_out_fifo;
  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
  localparam logic [13:0] BASE  = 14'h0080;

  logic mclk = 1'b0;
  logic puc_rst;
  always #5 mclk = ~mclk;

  per_out_fifo_if bus();

  per_out_fifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL)) dut (
    .mclk(mclk),
    .puc_rst(puc_rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue plus two sticky flags.
  logic [15:0] q[$];
  bit          ovf_m;
  bit          done_m;
  logic [15:0] popped[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_block();
    return bus.per_en && ((bus.per_addr >> 2) == (BASE >> 2));
  endfunction

  function automatic logic [15:0] exp_dout();
    logic [15:0] r;
    r = 16'h0000;
    if (in_block() && bus.per_we == 2'b00) begin
      case (bus.per_addr & 14'd3)
        14'd0: r = (q.size() != 0) ? q[0] : 16'h0000;
        14'd1: r = {8'(q.size()), 4'b0000, done_m, ovf_m,
                    (q.size() == DEPTH), (q.size() == 0)};
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  // Check every output against the model, advance the model by one clock, then clock.
  task automatic tick();
    bit          wr, push_req, ctrl, flush, clr, pop, nd, no;
    logic [15:0] w, word;
    #1;
    chk("out_valid", bus.out_valid, (q.size() != 0) ? 16'd1 : 16'd0);
    chk("out_data", bus.out_data, (q.size() != 0) ? q[0] : 16'h0000);
    chk("done", bus.done, done_m ? 16'd1 : 16'd0);
    chk("per_dout", bus.per_dout, exp_dout());
    if (puc_rst) begin
      q.delete();
      ovf_m  = 1'b0;
      done_m = 1'b0;
    end else begin
      wr       = (bus.per_we != 2'b00);
      push_req = in_block() && wr && ((bus.per_addr & 14'd3) == 14'd0);
      ctrl     = in_block() && wr && ((bus.per_addr & 14'd3) == 14'd2);
      flush    = ctrl && bus.per_din[1];
      clr      = ctrl && bus.per_din[0];
      word     = {bus.per_we[1] ? bus.per_din[15:8] : 8'h00,
                  bus.per_we[0] ? bus.per_din[7:0]  : 8'h00};
      pop      = (q.size() != 0) && bus.out_ready && !flush;
      nd = clr ? 1'b0 : done_m;
      no = clr ? 1'b0 : ovf_m;
      if (flush) q.delete();
      else begin
        if (pop) begin
          w = q.pop_front();
          popped.push_back(w);
          if (w == 16'h0000) nd = 1'b1;
        end
        if (push_req) begin
          if (q.size() < DEPTH) q.push_back(word);
          else no = 1'b1;
        end
      end
      done_m = nd;
      ovf_m  = no;
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_bus();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.per_addr = 14'h0000;
    bus.per_din  = 16'h0000;
  endtask

  task automatic wr(input int off, input logic [1:0] we, input logic [15:0] din);
    bus.per_en   = 1'b1;
    bus.per_addr = 14'(BASE + 14'(off));
    bus.per_we   = we;
    bus.per_din  = din;
    tick();
    idle_bus();
  endtask

  task automatic rd(input int off, output logic [15:0] v);
    bus.per_en   = 1'b1;
    bus.per_addr = 14'(BASE + 14'(off));
    bus.per_we   = 2'b00;
    #1;
    v = bus.per_dout;
    tick();
    idle_bus();
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] v;
  logic [15:0] exp1 [3] = '{16'h1234, 16'h0005, 16'hBEEF};
  int          r;
  int          n0;

  initial begin
    idle_bus();
    bus.out_ready = 1'b0;
    puc_rst = 1'b1;
    @(posedge mclk); #1;
    tick();
    puc_rst = 1'b0;
    chk("rst_valid", bus.out_valid, 16'd0);
    chk("rst_data", bus.out_data, 16'h0000);
    chk("rst_dout", bus.per_dout, 16'h0000);

    // 1: three writes, then back-to-back drain
    wr(0, 2'b11, 16'h1234);
    wr(0, 2'b11, 16'h0005);
    wr(0, 2'b11, 16'hBEEF);
    rd(1, v);
    chk("t1_status", v, 16'h0300);
    chk("t1_head", bus.out_data, 16'h1234);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_drain", bus.out_data, exp1[i]);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t1_empty_valid", bus.out_valid, 16'd0);
    rd(1, v);
    chk("t1_status_end", v, 16'h0001);

    // 2: overflow on the 17th word
    for (int i = 1; i <= 17; i++) wr(0, 2'b11, 16'(i));
    rd(1, v);
    chk("t2_status", v, 16'h1006);
    popped.delete();
    drain(17);
    chk("t2_count", 16'(popped.size()), 16'd16);
    for (int i = 0; i < 16; i++)
      if (i < popped.size()) chk("t2_word", popped[i], 16'(i + 1));
    wr(2, 2'b11, 16'h0001);

    // 3: push while full with a same-cycle pop
    for (int i = 1; i <= 16; i++) wr(0, 2'b11, 16'(i));
    popped.delete();
    bus.out_ready = 1'b1;
    wr(0, 2'b11, 16'hAAAA);
    bus.out_ready = 1'b0;
    rd(1, v);
    chk("t3_status", v, 16'h1002);
    drain(16);
    chk("t3_count", 16'(popped.size()), 16'd17);
    if (popped.size() == 17) begin
      chk("t3_first", popped[0], 16'h0001);
      chk("t3_16th", popped[16], 16'hAAAA);
    end

    // 4: byte writes
    popped.delete();
    wr(0, 2'b01, 16'h5678);
    wr(0, 2'b10, 16'h5678);
    drain(2);
    if (popped.size() == 2) begin
      chk("t4_low", popped[0], 16'h0078);
      chk("t4_high", popped[1], 16'h5600);
    end else chk("t4_count", 16'(popped.size()), 16'd2);

    // 5: end marker sets done
    wr(0, 2'b11, 16'h0007);
    wr(0, 2'b11, 16'h0000);
    bus.out_ready = 1'b1;
    tick();
    chk("t5_done_early", bus.done, 16'd0);
    tick();
    bus.out_ready = 1'b0;
    chk("t5_done", bus.done, 16'd1);
    rd(1, v);
    chk("t5_status", v, 16'h0009);
    wr(2, 2'b11, 16'h0001);
    chk("t5_done_clr", bus.done, 16'd0);
    rd(1, v);
    chk("t5_status_clr", v, 16'h0001);

    // 6: flush beats pop; reset mid-drain
    for (int i = 1; i <= 5; i++) wr(0, 2'b11, 16'(i + 32));
    popped.delete();
    bus.out_ready = 1'b1;
    wr(2, 2'b11, 16'h0002);
    bus.out_ready = 1'b0;
    chk("t6_flush_valid", bus.out_valid, 16'd0);
    chk("t6_no_pop", 16'(popped.size()), 16'd0);
    rd(1, v);
    chk("t6_flush_status", v, 16'h0001);
    for (int i = 1; i <= 4; i++) wr(0, 2'b11, 16'(i + 64));
    bus.out_ready = 1'b1;
    tick();
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    bus.out_ready = 1'b0;
    chk("t6_rst_valid", bus.out_valid, 16'd0);
    rd(1, v);
    chk("t6_rst_status", v, 16'h0001);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      puc_rst       = ($urandom_range(0, 199) == 0);
      bus.per_en    = ($urandom_range(0, 3) != 0);
      r             = $urandom_range(0, 9);
      n0            = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
      bus.per_addr  = 14'(BASE + 14'(n0));
      bus.per_we    = 2'($urandom_range(0, 3));
      bus.per_din   = 16'($urandom);
      if (n0 == 2 && $urandom_range(0, 3) != 0) bus.per_din[1] = 1'b0;
      if (n0 == 0 && $urandom_range(0, 7) == 0) bus.per_din = 16'h0000;
      bus.out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    puc_rst = 1'b0;
    idle_bus();
    bus.out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
